// File: rtl/load_store_unit.sv
// Memory-access stage: takes the ALU result as an effective address or pass-through value,
// runs one request/grant/response transaction per load or store, and hands writeback an extended result.
module load_store_unit #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] store_data_i,
    input  logic [4:0]        rd_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DWIDTH-1:0] res_o,
    output logic [4:0]        rd_o,
    output logic              fault_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    output logic [1:0]        state_o
);

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t            state;
    logic              is_load_q;
    logic [2:0]        funct3_q;
    logic [AWIDTH-1:0] addr_q;

    logic              accept;
    logic              is_load;
    logic              is_store;
    logic              misaligned;
    logic              unsupported;
    logic              fault;
    logic [3:0]        be_next;
    logic [DWIDTH-1:0] wdata_next;
    logic [DWIDTH-1:0] shifted;
    logic [DWIDTH-1:0] load_val;

    // Valid/ready: a transfer happens on a cycle where both valid and ready are high at the
    // clock edge; the sender holds its payload stable while valid is high and ready is low.
    assign ready_o = (state == IDLE) || ((state == OUT) && ready_i);
    assign accept  = valid_i && ready_o;
    assign state_o = state;

    always_comb begin
        is_load     = (opcode_i == OPCODE_LOAD);
        is_store    = (opcode_i == OPCODE_STORE);
        misaligned  = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                      ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        unsupported = is_load ? ((funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111))
                              : (funct3_i >= 3'b011);
        fault       = (is_load || is_store) && (misaligned || unsupported);

        case (funct3_i[1:0])
            2'b00:   be_next = 4'b0001 << addr_i[1:0];
            2'b01:   be_next = 4'b0011 << addr_i[1:0];
            default: be_next = 4'b1111;
        endcase

        // Narrow stores replicate across lanes so the byte enables alone select the target bytes.
        case (funct3_i[1:0])
            2'b00:   wdata_next = {4{store_data_i[7:0]}};
            2'b01:   wdata_next = {2{store_data_i[15:0]}};
            default: wdata_next = store_data_i;
        endcase
    end

    always_comb begin
        shifted = mem_rdata_i >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_val = {16'd0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            is_load_q   <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= '0;
            valid_o     <= 1'b0;
            res_o       <= '0;
            rd_o        <= 5'd0;
            fault_o     <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= 4'd0;
            mem_wdata_o <= '0;
        end else begin
            case (state)
                IDLE, OUT: begin
                    if (accept) begin
                        is_load_q <= is_load;
                        funct3_q  <= funct3_i;
                        addr_q    <= addr_i;
                        rd_o      <= rd_i;
                        if ((is_load || is_store) && !fault) begin
                            state       <= REQ;
                            valid_o     <= 1'b0;
                            fault_o     <= 1'b0;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= is_store;
                            mem_addr_o  <= {addr_i[AWIDTH-1:2], 2'b00};
                            mem_be_o    <= be_next;
                            mem_wdata_o <= wdata_next;
                        end else begin
                            state   <= OUT;
                            valid_o <= 1'b1;
                            res_o   <= addr_i;
                            fault_o <= fault;
                        end
                    end else if (state == OUT && ready_i) begin
                        state   <= IDLE;
                        valid_o <= 1'b0;
                        fault_o <= 1'b0;
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        if (is_load_q) begin
                            state <= WAIT;
                        end else begin
                            state   <= OUT;
                            valid_o <= 1'b1;
                            res_o   <= addr_q;
                            fault_o <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        state   <= OUT;
                        valid_o <= 1'b1;
                        res_o   <= load_val;
                        fault_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single transactions plus
// hand-written sequences for reset, back-to-back, grant-stall and writeback-stall cases.
module tb_load_store_unit;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;

  logic        clk_i;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic [4:0]  rd_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] res_o;
  logic [4:0]  rd_o;
  logic        fault_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  load_store_unit #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .opcode_i     (opcode_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .rd_i         (rd_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .res_o        (res_o),
    .rd_o         (rd_o),
    .fault_o      (fault_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .state_o      (state_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        exp_req;
    logic        exp_we;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_res;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [4:0] rd);
    valid_i      = 1'b1;
    opcode_i     = op;
    funct3_i     = f3;
    addr_i       = a;
    store_data_i = sd;
    rd_i         = rd;
  endtask

  // one transaction with immediate grant, rvalid the cycle after grant, ready_i held high
  task automatic run_vec(input vec_t v);
    drive_op(v.opcode, v.f3, v.addr, v.sdata, v.rd);
    tick();
    valid_i = 1'b0;
    if (v.exp_req) begin
      check({v.name, " req"},   {31'd0, mem_req_o}, 32'd1);
      check({v.name, " we"},    {31'd0, mem_we_o}, {31'd0, v.exp_we});
      check({v.name, " maddr"}, mem_addr_o, v.exp_maddr);
      check({v.name, " be"},    {28'd0, mem_be_o}, {28'd0, v.exp_be});
      if (v.exp_we) check({v.name, " wdata"}, mem_wdata_o, v.exp_wdata);
      check({v.name, " valid_early"}, {31'd0, valid_o}, 32'd0);
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
      check({v.name, " req_drop"}, {31'd0, mem_req_o}, 32'd0);
      if (!v.exp_we) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = v.rdata;
        tick();
        mem_rvalid_i = 1'b0;
      end
    end else begin
      check({v.name, " no_req"}, {31'd0, mem_req_o}, 32'd0);
    end
    check({v.name, " valid"}, {31'd0, valid_o}, 32'd1);
    check({v.name, " res"},   res_o, v.exp_res);
    check({v.name, " fault"}, {31'd0, fault_o}, {31'd0, v.exp_fault});
    check({v.name, " rd"},    {27'd0, rd_o}, {27'd0, v.rd});
    tick();
    check({v.name, " idle"}, {30'd0, state_o}, 32'd0);
    check({v.name, " valid_off"}, {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    //            name         opcode    f3      addr          sdata         rd     rdata         req we  maddr         be       wdata         res           fault
    vecs[0]  = '{"sw",        OP_STORE, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 5'd1,  32'h0,        1, 1, 32'h0000_0104, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0104, 0};
    vecs[1]  = '{"sh",        OP_STORE, 3'b001, 32'h0000_1006, 32'h1234_ABCD, 5'd2,  32'h0,        1, 1, 32'h0000_1004, 4'b1100, 32'hABCD_ABCD, 32'h0000_1006, 0};
    vecs[2]  = '{"lb",        OP_LOAD,  3'b000, 32'h0000_2002, 32'h0,         5'd3,  32'h12F0_4455, 1, 0, 32'h0000_2000, 4'b0100, 32'h0,         32'hFFFF_FFF0, 0};
    vecs[3]  = '{"lbu",       OP_LOAD,  3'b100, 32'h0000_2002, 32'h0,         5'd4,  32'h12F0_4455, 1, 0, 32'h0000_2000, 4'b0100, 32'h0,         32'h0000_00F0, 0};
    vecs[4]  = '{"lh",        OP_LOAD,  3'b001, 32'h0000_2002, 32'h0,         5'd5,  32'h12F0_4455, 1, 0, 32'h0000_2000, 4'b1100, 32'h0,         32'h0000_12F0, 0};
    vecs[5]  = '{"lh_neg",    OP_LOAD,  3'b001, 32'h0000_2000, 32'h0,         5'd6,  32'h0000_8001, 1, 0, 32'h0000_2000, 4'b0011, 32'h0,         32'hFFFF_8001, 0};
    vecs[6]  = '{"lhu",       OP_LOAD,  3'b101, 32'h0000_2000, 32'h0,         5'd7,  32'h0000_8001, 1, 0, 32'h0000_2000, 4'b0011, 32'h0,         32'h0000_8001, 0};
    vecs[7]  = '{"lw",        OP_LOAD,  3'b010, 32'h0000_3000, 32'h0,         5'd8,  32'hCAFE_F00D, 1, 0, 32'h0000_3000, 4'b1111, 32'h0,         32'hCAFE_F00D, 0};
    vecs[8]  = '{"lw_mis",    OP_LOAD,  3'b010, 32'h0000_3001, 32'h0,         5'd9,  32'h0,        0, 0, 32'h0,         4'b0000, 32'h0,         32'h0000_3001, 1};
    vecs[9]  = '{"ld_f3_110", OP_LOAD,  3'b110, 32'h0000_0040, 32'h0,         5'd10, 32'h0,        0, 0, 32'h0,         4'b0000, 32'h0,         32'h0000_0040, 1};
    vecs[10] = '{"sd_unsup",  OP_STORE, 3'b011, 32'h0000_0008, 32'h0,         5'd11, 32'h0,        0, 0, 32'h0,         4'b0000, 32'h0,         32'h0000_0008, 1};
    vecs[11] = '{"add",       OP_ADD,   3'b000, 32'h0000_5555, 32'h0,         5'd0,  32'h0,        0, 0, 32'h0,         4'b0000, 32'h0,         32'h0000_5555, 0};

    rst_ni       = 1'b0;
    valid_i      = 1'b0;
    opcode_i     = 7'd0;
    funct3_i     = 3'd0;
    addr_i       = 32'd0;
    store_data_i = 32'd0;
    rd_i         = 5'd0;
    ready_i      = 1'b1;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'd0;
    tick();
    tick();
    check("rst ready_o", {31'd0, ready_o}, 32'd1);
    check("rst valid_o", {31'd0, valid_o}, 32'd0);
    check("rst mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst state",   {30'd0, state_o}, 32'd0);
    rst_ni = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // reset while a load request is outstanding
    drive_op(OP_LOAD, 3'b010, 32'h0000_0100, 32'h0, 5'd3);
    tick();
    valid_i = 1'b0;
    check("rstreq req_before", {31'd0, mem_req_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("rstreq req",   {31'd0, mem_req_o}, 32'd0);
    check("rstreq valid", {31'd0, valid_o}, 32'd0);
    check("rstreq ready", {31'd0, ready_o}, 32'd1);
    #2 rst_ni = 1'b1;
    tick();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h5A5A_5A5A;
    tick();
    mem_rvalid_i = 1'b0;
    check("rstreq late_rvalid", {31'd0, valid_o}, 32'd0);
    tick();
    check("rstreq still_idle", {31'd0, valid_o}, 32'd0);
    check("rstreq state", {30'd0, state_o}, 32'd0);

    // three back-to-back pass-through ops, one result per cycle
    ready_i = 1'b1;
    drive_op(OP_ADD, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h0000_1234);
      tick();
      check("b2b valid", {31'd0, valid_o}, 32'd1);
      check("b2b res",   res_o, exp_q.pop_front());
      check("b2b rd",    {27'd0, rd_o}, 32'd5);
      check("b2b ready", {31'd0, ready_o}, 32'd1);
    end
    valid_i = 1'b0;
    tick();
    check("b2b drain", {31'd0, valid_o}, 32'd0);
    check("b2b queue_empty", exp_q.size(), 32'd0);

    // byte store with grant held off for three cycles
    drive_op(OP_STORE, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd0);
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("sb_stall req",   {31'd0, mem_req_o}, 32'd1);
      check("sb_stall we",    {31'd0, mem_we_o}, 32'd1);
      check("sb_stall addr",  mem_addr_o, 32'h0000_1000);
      check("sb_stall be",    {28'd0, mem_be_o}, 32'h0000_0008);
      check("sb_stall wdata", mem_wdata_o, 32'hA5A5_A5A5);
      check("sb_stall ready", {31'd0, ready_o}, 32'd0);
      tick();
    end
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    check("sb_stall valid", {31'd0, valid_o}, 32'd1);
    check("sb_stall fault", {31'd0, fault_o}, 32'd0);
    check("sb_stall req_drop", {31'd0, mem_req_o}, 32'd0);
    check("sb_stall res", res_o, 32'h0000_1003);
    tick();

    // load result held while writeback stalls
    ready_i = 1'b0;
    drive_op(OP_LOAD, 3'b010, 32'h0000_3000, 32'h0, 5'd9);
    tick();
    valid_i   = 1'b0;
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1122_3344;
    tick();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      check("wb_stall valid", {31'd0, valid_o}, 32'd1);
      check("wb_stall res",   res_o, 32'h1122_3344);
      check("wb_stall rd",    {27'd0, rd_o}, 32'd9);
      check("wb_stall ready", {31'd0, ready_o}, 32'd0);
      tick();
    end
    ready_i = 1'b1;
    #1;
    check("wb_stall ready_on", {31'd0, ready_o}, 32'd1);
    tick();
    check("wb_stall handoff", {31'd0, valid_o}, 32'd0);
    check("wb_stall idle", {30'd0, state_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
